// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: streams bytes MSB-first on MOSI while capturing MISO,
// holding nCS low across a burst until a byte tagged tx_last has completed.
module spi_master_tx #(
   parameter int CLK_DIV  = 2,
   parameter int CS_SETUP = 1,
   parameter int CS_HOLD  = 1,
   parameter int CS_IDLE  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       spi_nCS,
   output logic       spi_sck,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_LINK  = 3'd3,
      S_HOLD  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
   localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
   localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
   localparam logic [15:0] GAP_END   = 16'(CS_IDLE - 1);

   state_t      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [15:0] tmr_q, tmr_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic        last_q, last_d;
   logic        sck_q, sck_d;
   logic        ncs_q, ncs_d;
   logic        mosi_q, mosi_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        busy_q, busy_d;
   logic        accept;

   // Ready is decoded from state so a byte can be taken in the same cycle.
   assign tx_ready = reset & ((state_q == S_IDLE) | ((state_q == S_LINK) & ~last_q));
   assign accept   = tx_valid & tx_ready;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      tmr_d      = tmr_q;
      bit_d      = bit_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      last_d     = last_q;
      sck_d      = sck_q;
      ncs_d      = ncs_q;
      mosi_d     = mosi_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               tx_sh_d = tx_data;
               last_d  = tx_last;
               mosi_d  = tx_data[7];
               ncs_d   = 1'b0;
               sck_d   = 1'b0;
               div_d   = 16'd0;
               tmr_d   = 16'd0;
               bit_d   = 3'd0;
               state_d = (CS_SETUP == 0) ? S_SHIFT : S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            if (tmr_q == SETUP_END) begin
               tmr_d   = 16'd0;
               state_d = S_SHIFT;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         S_SHIFT: begin
            if (div_q == DIV_END) begin
               div_d = 16'd0;
               sck_d = ~sck_q;
               if (!sck_q) begin
                  rx_sh_d = {rx_sh_q[6:0], spi_miso};
               end else begin
                  // Falling edge: advance MOSI, or close the byte after the 8th fall.
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     rx_data_d  = rx_sh_q;
                     rx_valid_d = 1'b1;
                     state_d    = S_LINK;
                  end else begin
                     tx_sh_d = {tx_sh_q[6:0], 1'b0};
                     mosi_d  = tx_sh_q[6];
                  end
               end
            end else begin
               div_d = div_q + 16'd1;
            end
         end
         S_LINK: begin
            if (last_q) begin
               tmr_d = 16'd0;
               if (CS_HOLD == 0) begin
                  ncs_d   = 1'b1;
                  state_d = S_GAP;
               end else begin
                  state_d = S_HOLD;
               end
            end else if (accept) begin
               tx_sh_d = tx_data;
               last_d  = tx_last;
               mosi_d  = tx_data[7];
               div_d   = 16'd0;
               bit_d   = 3'd0;
               state_d = S_SHIFT;
            end else begin
               state_d = S_LINK;
            end
         end
         S_HOLD: begin
            if (tmr_q == HOLD_END) begin
               ncs_d   = 1'b1;
               tmr_d   = 16'd0;
               state_d = S_GAP;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         S_GAP: begin
            if (tmr_q == GAP_END) begin
               tmr_d   = 16'd0;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            ncs_d   = 1'b1;
            sck_d   = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         div_q      <= 16'd0;
         tmr_q      <= 16'd0;
         bit_q      <= 3'd0;
         tx_sh_q    <= 8'd0;
         rx_sh_q    <= 8'd0;
         last_q     <= 1'b0;
         sck_q      <= 1'b0;
         ncs_q      <= 1'b1;
         mosi_q     <= 1'b0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         tmr_q      <= tmr_d;
         bit_q      <= bit_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         last_q     <= last_d;
         sck_q      <= sck_d;
         ncs_q      <= ncs_d;
         mosi_q     <= mosi_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign spi_nCS  = ncs_q;
   assign spi_sck  = sck_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a bus monitor/slave model measures frames at the pin
// level and the stimulus compares them with timing computed from the frame rules.
module tb_spi_master_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, tx_valid, tx_last, sel, loop;
   logic [7:0] tx_data;
   logic       tx_valid0, tx_valid1;
   logic       tx_ready0, rx_valid0, busy0, ncs0, sck0, mosi0;
   logic       tx_ready1, rx_valid1, busy1, ncs1, sck1, mosi1;
   logic [7:0] rx_data0, rx_data1;
   logic       o_ready, o_rx_valid, o_busy, o_ncs, o_sck, o_mosi;
   logic [7:0] o_rx_data;
   logic       spi_miso, slave_bit;
   logic [7:0] slave_byte;
   logic [7:0] slave_resp [0:7];
   logic [5:0] fall_idx;

   assign tx_valid0  = tx_valid & ~sel;
   assign tx_valid1  = tx_valid & sel;
   assign o_ready    = sel ? tx_ready1 : tx_ready0;
   assign o_rx_valid = sel ? rx_valid1 : rx_valid0;
   assign o_rx_data  = sel ? rx_data1 : rx_data0;
   assign o_busy     = sel ? busy1 : busy0;
   assign o_ncs      = sel ? ncs1 : ncs0;
   assign o_sck      = sel ? sck1 : sck0;
   assign o_mosi     = sel ? mosi1 : mosi0;
   // CPHA=0 slave: presents MSB before the first rise, advances after each fall.
   assign slave_byte = slave_resp[fall_idx[5:3]];
   assign slave_bit  = slave_byte[3'd7 - fall_idx[2:0]];
   assign spi_miso   = loop ? o_mosi : slave_bit;

   spi_master_tx #(.CLK_DIV(2)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid0), .tx_last(tx_last),
      .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0),
      .spi_nCS(ncs0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(spi_miso));

   spi_master_tx #(.CLK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid1), .tx_last(tx_last),
      .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
      .spi_nCS(ncs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(spi_miso));

   // Monitor state, written only by the monitor process.
   int len_q[$], pulse_q[$], mbyte_q[$], rx_q[$], gap_q[$];
   int len, pulses, rises, nbits, hi_run, lo_run, gap_cnt, proto_err;
   logic gap_on, ncs_p, sck_p, mosi_p, sel_p;
   logic [7:0] bitacc;

   initial begin
      proto_err = 0; len = 0; pulses = 0; rises = 0; nbits = 0; hi_run = 0; lo_run = 0;
      gap_cnt = 0; gap_on = 1'b0; ncs_p = 1'b1; sck_p = 1'b0; mosi_p = 1'b0; sel_p = 1'b0;
      bitacc = 8'd0; fall_idx = 6'd0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            len = 0; pulses = 0; rises = 0; nbits = 0; hi_run = 0; lo_run = 0;
            gap_on = 1'b0; fall_idx = 6'd0;
         end else begin
            if (o_rx_valid) rx_q.push_back(int'(o_rx_data));
            if (!o_ncs) len++;
            if (!o_ncs && !o_busy) proto_err++;
            if (sel == sel_p && o_mosi != mosi_p && (o_sck || (o_ncs && ncs_p))) proto_err++;
            if (o_sck && !sck_p) begin
               pulses++;
               if (rises % 8 != 0 && lo_run != (sel ? 1 : 2)) proto_err++;
               rises++;
               bitacc = {bitacc[6:0], o_mosi};
               nbits++;
               if (nbits == 8) begin
                  mbyte_q.push_back(int'(bitacc));
                  nbits = 0;
               end
            end
            if (!o_sck && sck_p) begin
               if (hi_run != (sel ? 1 : 2)) proto_err++;
               fall_idx = fall_idx + 6'd1;
            end
            hi_run = o_sck ? hi_run + 1 : 0;
            lo_run = o_sck ? 0 : lo_run + 1;
            if (o_ncs && !ncs_p) begin
               len_q.push_back(len);
               pulse_q.push_back(pulses);
               len = 0; pulses = 0; rises = 0; nbits = 0; fall_idx = 6'd0;
               gap_on = 1'b1; gap_cnt = 0;
            end else if (gap_on) begin
               gap_cnt++;
               if (o_ready) begin
                  gap_q.push_back(gap_cnt);
                  gap_on = 1'b0;
               end
            end
         end
         ncs_p = o_ncs; sck_p = o_sck; mosi_p = o_mosi; sel_p = sel;
      end
   end

   int n_chk, n_fail;
   logic [7:0] fd [0:7];
   int fst [0:7];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int g = 0;
      while (!o_ready && g < 500) begin
         @(negedge clk);
         g++;
      end
   endtask

   // Sends fd[0..n-1]; fst[i] is the number of idle LINK cycles inserted before byte i.
   task automatic send_frame(input int n);
      int div, exp_len, g, v;
      div = sel ? 1 : 2;
      exp_len = 1 + 1;
      for (int i = 0; i < n; i++) begin
         if (i > 0 && fst[i] > 0) begin
            tx_valid = 1'b0;
            g = 0;
            while (!o_rx_valid && g < 500) begin
               @(negedge clk);
               g++;
            end
            check("link_strobe", o_rx_valid, 1'b1);
            for (int k = 0; k < fst[i]; k++) begin
               check("stall_ready", o_ready, 1'b1);
               check("stall_ncs", o_ncs, 1'b0);
               check("stall_sck", o_sck, 1'b0);
               @(negedge clk);
            end
         end
         tx_data = fd[i]; tx_last = (i == n - 1); tx_valid = 1'b1;
         wait_ready();
         check("accept_ready", o_ready, 1'b1);
         @(negedge clk);
         exp_len += 16 * div + 1 + ((i > 0) ? fst[i] : 0);
      end
      tx_valid = 1'b0; tx_last = 1'b0;
      g = 0;
      while (gap_q.size() == 0 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check("frame_done", 32'(gap_q.size()), 32'd1);
      v = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
      check("gap_cycles", v, 2);
      v = (len_q.size() > 0) ? len_q.pop_front() : -1;
      check("ncs_low_cycles", v, exp_len);
      v = (pulse_q.size() > 0) ? pulse_q.pop_front() : -1;
      check("sck_pulses", v, 8 * n);
      check("rx_count", 32'(rx_q.size()), 32'(n));
      check("mosi_count", 32'(mbyte_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         v = (mbyte_q.size() > 0) ? mbyte_q.pop_front() : -1;
         check("mosi_byte", v, int'(fd[i]));
         v = (rx_q.size() > 0) ? rx_q.pop_front() : -1;
         check("rx_byte", v, loop ? int'(fd[i]) : int'(slave_resp[i]));
      end
      check("protocol_errors", proto_err, 0);
      check("idle_busy", o_busy, 1'b0);
      check("idle_ncs", o_ncs, 1'b1);
   endtask

   initial begin
      int r, rxn, n;
      logic sp;
      n_chk = 0; n_fail = 0;
      reset = 1'b0; sel = 1'b0; loop = 1'b1;
      tx_data = 8'hAA; tx_valid = 1'b1; tx_last = 1'b1;
      for (int i = 0; i < 8; i++) begin
         slave_resp[i] = 8'd0;
         fd[i] = 8'd0;
         fst[i] = 0;
      end
      repeat (3) @(negedge clk);
      check("rst_ncs", o_ncs, 1'b1);
      check("rst_sck", o_sck, 1'b0);
      check("rst_mosi", o_mosi, 1'b0);
      check("rst_rx_valid", o_rx_valid, 1'b0);
      check("rst_rx_data", o_rx_data, 8'h00);
      check("rst_busy", o_busy, 1'b0);
      check("rst_ready", o_ready, 1'b0);
      check("rst_ncs1", ncs1, 1'b1);
      reset = 1'b1; tx_valid = 1'b0;
      @(negedge clk);
      check("idle_ready", o_ready, 1'b1);
      check("idle_busy0", o_busy, 1'b0);

      // Single byte loopback
      fd[0] = 8'hA5;
      send_frame(1);

      // Burst, valid held high
      fd[0] = 8'h12; fd[1] = 8'h34; fst[1] = 0;
      send_frame(2);

      // Stall between bytes
      fd[0] = 8'hFF; fd[1] = 8'h00; fst[1] = 20;
      send_frame(2);
      fst[1] = 0;

      // MISO from slave model
      loop = 1'b0; slave_resp[0] = 8'h3C; fd[0] = 8'h00;
      send_frame(1);
      loop = 1'b1;

      // Reset after the third SCK rise
      tx_data = 8'h81; tx_last = 1'b1; tx_valid = 1'b1;
      wait_ready();
      @(negedge clk);
      tx_valid = 1'b0;
      r = 0; sp = o_sck;
      for (int g = 0; g < 500 && r < 3; g++) begin
         @(negedge clk);
         if (o_sck && !sp) r++;
         sp = o_sck;
      end
      check("third_rise", r, 3);
      reset = 1'b0;
      rxn = rx_q.size();
      @(negedge clk);
      check("mid_rst_ncs", o_ncs, 1'b1);
      check("mid_rst_sck", o_sck, 1'b0);
      check("mid_rst_mosi", o_mosi, 1'b0);
      check("mid_rst_busy", o_busy, 1'b0);
      check("mid_rst_rx_valid", o_rx_valid, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_no_rx", 32'(rx_q.size()), 32'(rxn));
      check("mid_rst_ready", o_ready, 1'b1);
      fd[0] = 8'h81;
      send_frame(1);

      // CLK_DIV=1 instance
      sel = 1'b1;
      @(negedge clk);
      fd[0] = 8'h5A;
      send_frame(1);

      // Randomised frames against the frame-timing model
      for (int f = 0; f < 12; f++) begin
         sel = 1'($urandom_range(0, 1));
         loop = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 3);
         for (int i = 0; i < 8; i++) begin
            fd[i] = 8'($urandom);
            slave_resp[i] = 8'($urandom);
            fst[i] = (i == 0) ? 0 : $urandom_range(0, 4);
         end
         @(negedge clk);
         send_frame(n);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI mode-0 initiator that drives the LED SPI demultiplexer's slave port: spi_nCS, spi_sck, spi_mosi out, spi_miso in.
- Takes bytes on a valid/ready stream, shifts them out MSB-first and captures MISO at the same time.
- Keeps chip-select low across a burst until a byte tagged tx_last completes.
- Used on-board as the bench/bring-up driver for the mux, and in-fabric where a local controller feeds the mux.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period (must be >= 1).
- CS_SETUP, 1, clk cycles from nCS falling to start of the first SCK half-period.
- CS_HOLD, 1, clk cycles from last SCK falling edge to nCS rising.
- CS_IDLE, 2, clk cycles nCS stays high before the next frame may start (must be >= 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data/tx_last valid
- tx_last  in  1  byte closes the frame (nCS released after it)
- tx_ready  out  1  byte accepted when tx_valid & tx_ready at a clk rising edge
- rx_data  out  8  byte captured from MISO
- rx_valid  out  1  one-cycle strobe; rx_data valid
- busy  out  1  high in any state other than IDLE
- spi_nCS  out  1  chip select, active low
- spi_sck  out  1  serial clock, idles low (CPOL=0)
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in, sampled on SCK rise (CPHA=0)

Behaviour:
- Single clock domain; all outputs registered except tx_ready (decoded from state, forced 0 while reset is low).
- Reset (reset==0 at a clk edge), including mid-byte: state=IDLE; spi_nCS=1, spi_sck=0, spi_mosi=0, rx_valid=0, rx_data=0, busy=0; all counters cleared. No partial rx_valid is issued.
- States:
  - IDLE: tx_ready=1. On accept, latch tx_data into the shift register and tx_last into last_q. Next cycle: nCS=0, mosi=tx_data[7]; go to SETUP.
  - SETUP: hold for CS_SETUP cycles, then go to SHIFT.
  - SHIFT: the half-period counter counts CLK_DIV cycles, then toggles sck.
    - SCK rise: shift spi_miso into the rx shift register LSB.
    - SCK fall: if bits remain, mosi takes the next bit.
    - 8 rises and 8 falls take exactly 16*CLK_DIV cycles. After the 8th fall, go to LINK.
  - LINK: one or more cycles, sck=0, nCS=0.
    - On LINK entry, rx_data is loaded and rx_valid=1 for exactly one cycle.
    - If last_q: go to HOLD; tx_ready=0.
    - Else tx_ready=1. On accept, latch the new byte, mosi=bit7 next cycle, go to SHIFT directly (no SETUP). Without tx_valid, stay in LINK indefinitely with nCS held low.
  - HOLD: CS_HOLD cycles, then nCS=1; go to GAP.
  - GAP: CS_IDLE cycles with nCS=1, then go to IDLE.
- tx_ready is 0 in SETUP, SHIFT, HOLD and GAP. tx_valid there is ignored; the data is held by the source.
- Simultaneous events:
  - tx_valid in the same cycle as reset low: not accepted.
  - spi_miso is sampled only on the clk edge where sck goes 0->1.
- busy=1 from the cycle after accept until return to IDLE.
- MOSI is stable for a full SCK period around every rising edge. mosi is not changed by HOLD/GAP; it keeps its last value until the next frame.

Test Plan:
- CLK_DIV=2, defaults; send 0xA5 with tx_last=1, spi_miso tied to spi_mosi:
  - nCS low for 1+32+1+1 = 35 cycles.
  - 8 sck pulses, each 2 cycles high / 2 cycles low; mosi sequence 1,0,1,0,0,1,0,1.
  - rx_valid once with rx_data=0xA5.
  - tx_ready returns 1 exactly CS_IDLE=2 cycles after nCS rises.
- Burst 0x12 (last=0) then 0x34 (last=1), tx_valid held high:
  - nCS stays low across both bytes; 16 sck pulses.
  - Only a single LINK cycle between bytes.
  - Two rx_valid strobes.
- Stall: 0xFF (last=0), then tx_valid low for 20 cycles, then 0x00 (last=1):
  - nCS low, sck low for the whole stall, tx_ready=1 throughout.
  - Frame completes normally.
- MISO capture: spi_miso driven from a slave model returning 0x3C while sending 0x00 -> rx_data=0x3C.
- Reset low after the 3rd sck rise of 0x81:
  - Next edge: nCS=1, sck=0, mosi=0, busy=0, no rx_valid.
  - A fresh 0x81 afterwards transmits correctly.
- CLK_DIV=1: send 0x5A -> sck toggles every clk; byte takes 16 cycles in SHIFT; rx_data=0x5A in loopback.
